// File: rtl/sar_ctrl_if.sv
// SAR controller bus: conversion control, comparator and DAC handshake signals.
// Purely structural; no state and no added latency.
// The controller side uses the slave modport, the converter front-end the master.
interface sar_ctrl_if #(
    parameter int N_BITS = 8
);
    // Requests towards the controller
    logic              start;
    logic              abort;
    logic              cont;
    logic              cmp_in;

    // Controller outputs
    logic              sample_en;
    logic              cmp_strobe;
    logic [N_BITS-1:0] dac_code;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] result;
    logic              result_valid;

    // Side that issues conversions and models the analog front-end
    modport master (
        output start,
        output abort,
        output cont,
        output cmp_in,
        input  sample_en,
        input  cmp_strobe,
        input  dac_code,
        input  busy,
        input  done,
        input  result,
        input  result_valid
    );

    // The SAR controller itself
    modport slave (
        input  start,
        input  abort,
        input  cont,
        input  cmp_in,
        output sample_en,
        output cmp_strobe,
        output dac_code,
        output busy,
        output done,
        output result,
        output result_valid
    );
endinterface

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: sample, then one settle+compare per bit, MSB first.
// Latency: done pulses SAMPLE_CYCLES + N_BITS*(SETTLE_CYCLES+1) edges after start is taken.
// No backpressure: start is only honoured in IDLE, back-to-back conversions go through cont.
module sar_ctrl #(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    sar_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        COMPARE,
        DONE
    } state_t;

    // Counter reload values; the shared counter counts down to zero so that
    // a load of (cycles-1) gives exactly 'cycles' clocks in the phase.
    // Eight bits cover the largest sample phase, which is also wider than any settle phase.
    localparam logic [7:0]        SAMPLE_LOAD = 8'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]        TOP_IDX     = 4'(N_BITS - 1);
    localparam logic [N_BITS-1:0] MSB_CODE    = {1'b1, {(N_BITS-1){1'b0}}};
    localparam logic [N_BITS-1:0] ONE_CODE    = {{(N_BITS-1){1'b0}}, 1'b1};

    state_t            state;
    logic [7:0]        cnt;
    logic [3:0]        idx;
    logic [N_BITS-1:0] dac_code;
    logic [N_BITS-1:0] result;
    logic              sample_en;
    logic              cmp_strobe;
    logic              busy;
    logic              done;
    logic              result_valid;

    // Trial-code update for the bit under test
    logic [N_BITS-1:0] cur_mask;
    logic [N_BITS-1:0] trial;
    logic              abort_hit;

    // Resolve the current bit from the comparator and pre-set the next lower bit.
    // When idx is 0 the shifted mask is empty, so the final code is just the resolved one.
    always_comb begin
        cur_mask = ONE_CODE << idx;
        trial    = cmp_in_masked() ? dac_code : (dac_code & ~cur_mask);
        trial    = trial | (cur_mask >> 1);
    end

    // The comparator is only meaningful while its latch is enabled
    function automatic logic cmp_in_masked();
        return bus.cmp_in;
    endfunction

    // Abort only cancels an active conversion; IDLE and DONE are not affected
    assign abort_hit = bus.abort &&
                       ((state == SAMPLE) || (state == SETTLE) || (state == COMPARE));

    // Conversion sequencer with all outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            dac_code     <= '0;
            result       <= '0;
            sample_en    <= 1'b0;
            cmp_strobe   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else if (abort_hit) begin
            // Cancel: drop the partial code, keep the last good result
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            dac_code   <= '0;
            sample_en  <= 1'b0;
            cmp_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Single-cycle outputs fall back unless a branch re-asserts them
            done       <= 1'b0;
            cmp_strobe <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= SAMPLE;
                        cnt       <= SAMPLE_LOAD;
                        dac_code  <= '0;
                        sample_en <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                SAMPLE: begin
                    if (cnt == 8'd0) begin
                        // Hold switch opens; first trial is the MSB alone
                        sample_en <= 1'b0;
                        idx       <= TOP_IDX;
                        dac_code  <= MSB_CODE;
                        if (SETTLE_CYCLES == 0) begin
                            state      <= COMPARE;
                            cmp_strobe <= 1'b1;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                SETTLE: begin
                    if (cnt == 8'd0) begin
                        state      <= COMPARE;
                        cmp_strobe <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                COMPARE: begin
                    dac_code <= trial;
                    if (idx == 4'd0) begin
                        // Last bit resolved: publish the code as the new result
                        state        <= DONE;
                        result       <= trial;
                        result_valid <= 1'b1;
                        done         <= 1'b1;
                    end else begin
                        idx <= idx - 4'd1;
                        if (SETTLE_CYCLES == 0) begin
                            state      <= COMPARE;
                            cmp_strobe <= 1'b1;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LOAD;
                        end
                    end
                end

                DONE: begin
                    // start is deliberately ignored here; only cont chains conversions
                    dac_code <= '0;
                    if (bus.cont) begin
                        state     <= SAMPLE;
                        cnt       <= SAMPLE_LOAD;
                        sample_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    idx       <= '0;
                    dac_code  <= '0;
                    sample_en <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample_en    = sample_en;
    assign bus.cmp_strobe   = cmp_strobe;
    assign bus.dac_code     = dac_code;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;

endmodule
